// File: rtl/fp_sqrt_radix_core.sv
// ---------------------------------------------------------------------------
// fp_sqrt_radix_core
//
// Iterative unsigned square-root engine used as the mantissa core of the FP
// square-root unit. The radicand R is scaled to X = R * 4^k, where
// k = ROOT_WIDTH - DATA_WIDTH/2. The engine returns Q = floor(sqrt(X)), the
// remainder X - Q^2 and an exact flag. It retires BITS_PER_CYCLE root bits
// per clock using a restoring digit-by-digit recurrence.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   start      in   request, accepted only while ready=1
//   radicand   in   DATA_WIDTH-bit unsigned radicand, sampled on accept
//   abort      in   cancel any operation and return to IDLE
//   ack        in   consumer takes the held result (only meaningful when done)
//   ready      out  a start would be accepted this cycle
//   done       out  result/remainder/exact are valid and held
//   result     out  ROOT_WIDTH-bit root Q
//   remainder  out  ROOT_WIDTH+1-bit final remainder
//   exact      out  remainder is zero
// ---------------------------------------------------------------------------
module fp_sqrt_radix_core #(
    parameter int DATA_WIDTH     = 26,
    parameter int ROOT_WIDTH     = 28,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] radicand,
    input  logic                  abort,
    input  logic                  ack,
    output logic                  ready,
    output logic                  done,
    output logic [ROOT_WIDTH-1:0] result,
    output logic [ROOT_WIDTH:0]   remainder,
    output logic                  exact
);

    localparam int K       = ROOT_WIDTH - DATA_WIDTH / 2;
    localparam int SHIFT_W = 2 * ROOT_WIDTH;
    localparam int REM_W   = ROOT_WIDTH + 2;
    localparam int N       = ROOT_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateT;

    stateT               state_q, state_d;
    logic [CNT_W-1:0]    iterCnt_q;
    logic [SHIFT_W-1:0]  radShift_q, radShift_d;
    logic [REM_W-1:0]    partRem_q, partRem_d;
    logic [ROOT_WIDTH-1:0] rootPart_q, rootPart_d;
    logic [ROOT_WIDTH-1:0] result_q;
    logic [ROOT_WIDTH:0]   remainder_q;
    logic                  exact_q;

    logic                  accept;
    logic                  lastIter;
    logic [SHIFT_W-1:0]    loadVal;

    // Handshake: we can take a new op from IDLE, or from DONE in the same
    // cycle the consumer acknowledges (this gives back-to-back issue with no
    // bubble). Abort overrides everything, so a start during abort is dropped.
    assign ready    = ~abort & ((state_q == IDLE) | ((state_q == DONE) & ack));
    assign accept   = start & ready;
    assign lastIter = (iterCnt_q == CNT_W'(1));
    assign done     = (state_q == DONE);

    assign result    = result_q;
    assign remainder = remainder_q;
    assign exact     = exact_q;

    // The radicand is pre-scaled by 4^k simply by placing it at the top of
    // the 2*ROOT_WIDTH shift register; the low 2k bits are zero.
    assign loadVal = SHIFT_W'(radicand) << (2 * K);

    // One cycle of the restoring recurrence. Each step pulls the next two
    // radicand bits into the partial remainder and trial-subtracts 4*Q+1.
    // The partial remainder before a step is at most 2*Q with Q still short
    // of full width, so dropping its top two bits on the shift loses nothing,
    // and ROOT_WIDTH+2 bits hold the trial subtraction without truncation.
    always_comb begin
        logic [REM_W-1:0]      remVar;
        logic [ROOT_WIDTH-1:0] rootVar;
        logic [SHIFT_W-1:0]    shiftVar;
        logic [REM_W-1:0]      trialSub;
        remVar   = partRem_q;
        rootVar  = rootPart_q;
        shiftVar = radShift_q;
        trialSub = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            remVar   = {remVar[ROOT_WIDTH-1:0], shiftVar[SHIFT_W-1 -: 2]};
            shiftVar = shiftVar << 2;
            trialSub = {rootVar, 2'b01};
            if (remVar >= trialSub) begin
                remVar  = remVar - trialSub;
                rootVar = (rootVar << 1) | ROOT_WIDTH'(1);
            end else begin
                rootVar = rootVar << 1;
            end
        end
        partRem_d  = remVar;
        rootPart_d = rootVar;
        radShift_d = shiftVar;
    end

    // Next-state logic. Abort is applied last so it wins over every other
    // transition, including a DONE->BUSY reissue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                if (lastIter) state_d = DONE;
            end
            DONE: begin
                if (ack) state_d = accept ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // State register; reset is asynchronous so done drops immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers. Accept loads fresh operands and clears the partial
    // root/remainder; each BUSY cycle advances the recurrence, and the last
    // iteration latches the outputs, which then stay put until the next
    // completion. Abort freezes the datapath; the stale contents are simply
    // ignored because the FSM has returned to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iterCnt_q   <= '0;
            radShift_q  <= '0;
            partRem_q   <= '0;
            rootPart_q  <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exact_q     <= 1'b0;
        end else if (accept) begin
            iterCnt_q  <= CNT_W'(N);
            radShift_q <= loadVal;
            partRem_q  <= '0;
            rootPart_q <= '0;
        end else if ((state_q == BUSY) && !abort) begin
            iterCnt_q  <= iterCnt_q - CNT_W'(1);
            radShift_q <= radShift_d;
            partRem_q  <= partRem_d;
            rootPart_q <= rootPart_d;
            if (lastIter) begin
                result_q    <= rootPart_d;
                remainder_q <= partRem_d[ROOT_WIDTH:0];
                exact_q     <= (partRem_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_fp_sqrt_radix_core.sv
// ---------------------------------------------------------------------------
// tb_fp_sqrt_radix_core
//
// Scoreboard bench for fp_sqrt_radix_core. Several instances with different
// width / bits-per-cycle settings run side by side on one clock. For each
// instance a stimulus process issues operations (directed then random) and
// pushes the expected root, remainder, exact flag and completion cycle; a
// separate monitor pops and compares whenever the instance presents a result.
// Expected values come from an integer square root found by binary search
// on q*q <= R*4^k.
// ---------------------------------------------------------------------------
module tb_fp_sqrt_radix_core;

    localparam int NCFG  = 5;
    localparam int NDIR  = 4;
    localparam int NRAND = 200;
    localparam int NOPS  = NDIR + NRAND;

    typedef struct {
        longint unsigned r;
        longint unsigned q;
        longint unsigned rem;
        bit              ex;
        int              expCycle;
    } expT;

    logic            clk = 1'b0;
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;
    logic [NCFG-1:0] finVec;

    always #5 clk = ~clk;

    // Free-running edge counter used to check completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Per-instance configuration: field 0 = DATA_WIDTH, 1 = ROOT_WIDTH,
    // 2 = BITS_PER_CYCLE.
    function automatic int cfgVal(input int g, input int field);
        int dw, rw, bpc;
        case (g)
            0:       begin dw = 8;  rw = 4;  bpc = 1; end
            1:       begin dw = 8;  rw = 8;  bpc = 2; end
            2:       begin dw = 26; rw = 28; bpc = 1; end
            3:       begin dw = 26; rw = 28; bpc = 2; end
            default: begin dw = 26; rw = 28; bpc = 4; end
        endcase
        if (field == 0) return dw;
        if (field == 1) return rw;
        return bpc;
    endfunction

    // Directed radicands issued first on each instance.
    function automatic longint unsigned dirR(input int g, input int i);
        longint unsigned v;
        if (g == 0) begin
            case (i) 0: v = 200; 1: v = 196; 2: v = 0; default: v = 255; endcase
        end else if (g == 1) begin
            case (i) 0: v = 2; 1: v = 255; 2: v = 0; default: v = 1; endcase
        end else begin
            case (i) 0: v = 64'h3FFFFFF; 1: v = 64'h2000000; 2: v = 0; default: v = 1; endcase
        end
        return v;
    endfunction

    // Largest q with q*q <= x.
    function automatic longint unsigned refSqrt(input longint unsigned x);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'd1 << 32;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= x) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    function automatic expT makeExp(input longint unsigned r, input int k, input int expCycle);
        expT e;
        longint unsigned x;
        x          = r << (2 * k);
        e.r        = r;
        e.q        = refSqrt(x);
        e.rem      = x - e.q * e.q;
        e.ex       = (e.rem == 0);
        e.expCycle = expCycle;
        return e;
    endfunction

    task automatic checkOutput(input int g, input string name,
                               input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL cfg%0d %s: got %0d, wanted %0d (t=%0t)", g, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfgBlk
        localparam int DW  = cfgVal(g, 0);
        localparam int RW  = cfgVal(g, 1);
        localparam int BPC = cfgVal(g, 2);
        localparam int N   = RW / BPC;
        localparam int K   = RW - DW / 2;

        logic          rst, start, abort, ack;
        logic          ready, done, exact;
        logic [DW-1:0] radicand;
        logic [RW-1:0] result;
        logic [RW:0]   remainder;
        expT           sbQ[$];
        expT           heldExp;
        bit            seen;
        bit            fin = 1'b0;

        assign finVec[g] = fin;

        fp_sqrt_radix_core #(
            .DATA_WIDTH    (DW),
            .ROOT_WIDTH    (RW),
            .BITS_PER_CYCLE(BPC)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .radicand (radicand),
            .abort    (abort),
            .ack      (ack),
            .ready    (ready),
            .done     (done),
            .result   (result),
            .remainder(remainder),
            .exact    (exact)
        );

        // Radicand picker: directed list first, then random with extra
        // weight on zero, all-ones and perfect squares.
        function automatic logic [DW-1:0] pickR(input int i);
            longint unsigned s;
            if (i < NDIR) return DW'(dirR(g, i));
            case ($urandom_range(0, 7))
                0: return '0;
                1: return '1;
                2: begin
                    s = longint'($urandom) & ((64'd1 << (DW / 2)) - 1);
                    return DW'(s * s);
                end
                default: return DW'({$urandom, $urandom});
            endcase
        endfunction

        // Called #1 after a rising edge; drives start for one cycle and
        // records the expected response if the op is meant to complete.
        task automatic applyStimulus(input logic [DW-1:0] r, input bit pushExp, input bit withAck);
            start    = 1'b1;
            radicand = r;
            ack      = withAck;
            @(negedge clk);
            checkOutput(g, "ready_at_start", 64'(ready), 1);
            if (pushExp) sbQ.push_back(makeExp(64'(r), K, cyc + 1 + N));
            @(posedge clk); #1;
            start = 1'b0;
            ack   = 1'b0;
        endtask

        task automatic waitDone(output bit ok);
            ok = 1'b0;
            for (int i = 0; i < N + 4; i++) begin
                @(negedge clk);
                if (done) begin
                    ok = 1'b1;
                    break;
                end
            end
            checkOutput(g, "done_within_budget", 64'(ok), 1);
        endtask

        task automatic releaseAck();
            ack = 1'b1;
            @(negedge clk);
            checkOutput(g, "ready_on_ack", 64'(ready), 1);
            @(posedge clk); #1;
            ack = 1'b0;
            @(negedge clk);
            checkOutput(g, "done_after_ack", 64'(done), 0);
            checkOutput(g, "ready_after_ack", 64'(ready), 1);
            @(posedge clk); #1;
        endtask

        // Monitor: a result is "new" on the first done cycle after it was
        // last consumed (ack), aborted or reset; while held it must not move.
        initial begin : monitor
            expT e;
            seen = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    seen = 1'b0;
                end else begin
                    if (done && !seen) begin
                        if (sbQ.size() == 0) begin
                            checkOutput(g, "done_without_request", 64'(done), 0);
                        end else begin
                            e       = sbQ.pop_front();
                            heldExp = e;
                            checkOutput(g, "root", 64'(result), e.q);
                            checkOutput(g, "remainder", 64'(remainder), e.rem);
                            checkOutput(g, "exact", 64'(exact), 64'(e.ex));
                            checkOutput(g, "latency_cycle", 64'(cyc), 64'(e.expCycle));
                        end
                        seen = 1'b1;
                    end else if (done) begin
                        checkOutput(g, "hold_root", 64'(result), heldExp.q);
                        checkOutput(g, "hold_remainder", 64'(remainder), heldExp.rem);
                        checkOutput(g, "hold_exact", 64'(exact), 64'(heldExp.ex));
                    end
                    if ((done && ack) || abort) seen = 1'b0;
                end
            end
        end

        // Stimulus: reset, directed + random ops with random hold times and
        // back-to-back reissue, then abort and asynchronous reset scenarios.
        initial begin : stim
            bit ok;
            int hold;
            rst      = 1'b1;
            start    = 1'b0;
            abort    = 1'b0;
            ack      = 1'b0;
            radicand = '0;
            repeat (2) @(negedge clk);
            checkOutput(g, "reset_ready", 64'(ready), 1);
            checkOutput(g, "reset_done", 64'(done), 0);
            checkOutput(g, "reset_result", 64'(result), 0);
            checkOutput(g, "reset_remainder", 64'(remainder), 0);
            checkOutput(g, "reset_exact", 64'(exact), 0);
            @(posedge clk); #1;
            rst = 1'b0;

            // ack while idle must not disturb anything
            ack = 1'b1;
            @(negedge clk);
            checkOutput(g, "idle_ack_ready", 64'(ready), 1);
            @(posedge clk); #1;
            ack = 1'b0;
            @(negedge clk);
            checkOutput(g, "idle_ack_done", 64'(done), 0);
            @(posedge clk); #1;

            applyStimulus(pickR(0), 1'b1, 1'b0);
            for (int i = 0; i < NOPS; i++) begin
                waitDone(ok);
                if (!ok) break;
                hold = (i < NDIR) ? 5 : $urandom_range(0, 3);
                repeat (hold) @(negedge clk);
                @(posedge clk); #1;
                if (i + 1 < NOPS && (i == 0 || $urandom_range(0, 1) == 1)) begin
                    applyStimulus(pickR(i + 1), 1'b1, 1'b1);
                end else begin
                    releaseAck();
                    if (i + 1 < NOPS) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk); #1;
                        end
                        applyStimulus(pickR(i + 1), 1'b1, 1'b0);
                    end
                end
            end

            // Abort in the third busy cycle with a simultaneous start.
            applyStimulus(pickR(NOPS), 1'b0, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            abort    = 1'b1;
            start    = 1'b1;
            radicand = DW'(5);
            @(negedge clk);
            checkOutput(g, "ready_during_abort", 64'(ready), 0);
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            @(negedge clk);
            checkOutput(g, "done_after_abort", 64'(done), 0);
            checkOutput(g, "ready_after_abort", 64'(ready), 1);
            repeat (N + 2) @(negedge clk);
            @(posedge clk); #1;
            applyStimulus(DW'(9), 1'b1, 1'b0);
            waitDone(ok);
            @(posedge clk); #1;
            releaseAck();

            // Asynchronous reset between edges while busy.
            applyStimulus(pickR(NOPS), 1'b0, 1'b0);
            repeat (3) @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            checkOutput(g, "async_rst_ready", 64'(ready), 1);
            checkOutput(g, "async_rst_done", 64'(done), 0);
            checkOutput(g, "async_rst_result", 64'(result), 0);
            checkOutput(g, "async_rst_remainder", 64'(remainder), 0);
            checkOutput(g, "async_rst_exact", 64'(exact), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            applyStimulus(DW'(0), 1'b1, 1'b0);
            waitDone(ok);
            @(posedge clk); #1;
            releaseAck();

            checkOutput(g, "scoreboard_drained", 64'(sbQ.size()), 0);
            fin = 1'b1;
        end
    end

    // Wait for every instance to finish (bounded), then report.
    initial begin : summary
        while (!(&finVec) && cyc < 80000) @(negedge clk);
        checkOutput(-1, "all_instances_finished", 64'(&finVec), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
